// File: rtl/xc_malu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : xc_malu_iter
//  Purpose  : Iterative multiply / divide / remainder unit. Multiplies one
//             multiplier bit per cycle (shift-add, or shift-XOR for
//             carryless), or divides one restoring step per cycle, on operand
//             magnitudes. A single FIX cycle then applies the sign correction.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          rising-edge clock for all state
//    reset          synchronous, active-high reset
//    rs1 / rs2      left / right operand (XLEN bits)
//    valid          request present, held with stable inputs until flush
//    flush          abort or retire the current operation
//    uop_div/mul/rem one-hot operation select
//    mod_lh_sign    rs1 is signed (and rs2 too for div/rem)
//    mod_rh_sign    rs2 is signed (mul only)
//    mod_carryless  GF(2) multiply, mul only
//    result         2*XLEN-bit result, held while ready
//    ready          result valid
// ============================================================================
module xc_malu_iter #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic              valid,
  input  logic              flush,
  input  logic              uop_div,
  input  logic              uop_mul,
  input  logic              uop_rem,
  input  logic              mod_lh_sign,
  input  logic              mod_rh_sign,
  input  logic              mod_carryless,
  output logic [2*XLEN-1:0] result,
  output logic              ready
);

  localparam int            CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_count;

  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting
  // multiplier.
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplier;
  // Divide datapath: partial remainder, dividend shifting into quotient.
  logic [XLEN-1:0]     r_divisor;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  // Captured op bits.
  logic                r_neg;
  logic                r_clmul;
  logic                r_is_mul;
  logic                r_is_rem;

  // --------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // --------------------------------------------------------------------------
  logic              w_op_ok;
  logic              w_start;
  logic              w_div_zero;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_neg_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;

  assign w_op_ok = ( uop_mul & ~uop_div & ~uop_rem) |
                   (~uop_mul &  uop_div & ~uop_rem) |
                   (~uop_mul & ~uop_div &  uop_rem);
  assign w_start    = valid & ~flush & w_op_ok;
  assign w_div_zero = (rs2 == '0);

  // Carryless multiply is sign-agnostic; div/rem take both signs from lh.
  assign w_a_signed = uop_mul ? (mod_lh_sign & ~mod_carryless) : mod_lh_sign;
  assign w_b_signed = uop_mul ? (mod_rh_sign & ~mod_carryless) : mod_lh_sign;
  assign w_a_neg    = w_a_signed & rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1 : rs1;
  assign w_b_mag    = w_b_neg ? -rs2 : rs2;
  // Remainder follows the dividend; product and quotient follow the XOR.
  assign w_neg_res  = uop_rem ? w_a_neg : (w_a_neg ^ w_b_neg);

  // --------------------------------------------------------------------------
  // Iteration steps
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_mul_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_rem_shift;
  logic [XLEN:0]     w_sub;
  logic              w_ge;

  assign w_mul_sum  = r_clmul ? (r_acc ^ r_mcand) : (r_acc + r_mcand);
  assign w_acc_next = r_mplier[0] ? w_mul_sum : r_acc;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor and the sign bit of the XLEN+1-bit difference
  // alone says whether the subtraction fits.
  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_sub       = w_rem_shift - {1'b0, r_divisor};
  assign w_ge        = ~w_sub[XLEN];

  // --------------------------------------------------------------------------
  // Sign correction applied in FIX
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_fix_result;

  always_comb begin
    w_fix_result = '0;
    if (r_is_mul) begin
      w_fix_result = r_neg ? -r_acc : r_acc;
    end else if (r_is_rem) begin
      w_fix_result = {{XLEN{1'b0}}, (r_neg ? -r_rem : r_rem)};
    end else begin
      w_fix_result = {{XLEN{1'b0}}, (r_neg ? -r_quo : r_quo)};
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (uop_mul)         w_next = S_MUL;
          else if (w_div_zero) w_next = S_DONE;
          else                 w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)                  w_next = S_IDLE;
        else if (r_count == C_LAST) w_next = S_FIX;
      end
      S_FIX: begin
        w_next = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (flush) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_neg     <= 1'b0;
      r_clmul   <= 1'b0;
      r_is_mul  <= 1'b0;
      r_is_rem  <= 1'b0;
      result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier  <= w_b_mag;
            r_divisor <= w_b_mag;
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_neg     <= w_neg_res;
            r_clmul   <= mod_carryless & uop_mul;
            r_is_mul  <= uop_mul;
            r_is_rem  <= uop_rem;
            // Divide by zero skips the iteration and answers immediately.
            if (!uop_mul && w_div_zero) begin
              result <= uop_rem ? {{XLEN{1'b0}}, rs1}
                                : {{XLEN{1'b0}}, {XLEN{1'b1}}};
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        S_DIV: begin
          r_rem   <= w_ge ? w_sub[XLEN-1:0] : w_rem_shift[XLEN-1:0];
          r_quo   <= {r_quo[XLEN-2:0], w_ge};
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          if (!flush) result <= w_fix_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xc_malu_iter
//  Purpose  : Directed self-checking bench for xc_malu_iter (XLEN=32 and a
//             second XLEN=64 instance), one task per scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xc_malu_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rs1, rs2;
  logic        valid, flush, uop_div, uop_mul, uop_rem;
  logic        mod_lh_sign, mod_rh_sign, mod_carryless;
  logic [63:0] result;
  logic        ready;

  logic [63:0]  rs1_w, rs2_w;
  logic         valid_w, flush_w;
  logic [127:0] result_w;
  logic         ready_w;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  xc_malu_iter #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
    .valid(valid), .flush(flush),
    .uop_div(uop_div), .uop_mul(uop_mul), .uop_rem(uop_rem),
    .mod_lh_sign(mod_lh_sign), .mod_rh_sign(mod_rh_sign),
    .mod_carryless(mod_carryless),
    .result(result), .ready(ready)
  );

  xc_malu_iter #(.XLEN(64)) dut_w (
    .clock(clock), .reset(reset), .rs1(rs1_w), .rs2(rs2_w),
    .valid(valid_w), .flush(flush_w),
    .uop_div(1'b0), .uop_mul(1'b1), .uop_rem(1'b0),
    .mod_lh_sign(1'b0), .mod_rh_sign(1'b0), .mod_carryless(1'b0),
    .result(result_w), .ready(ready_w)
  );

  // Drive one request, count edges (start edge = 1) until ready, then retire.
  task automatic run_op(input logic d, input logic m, input logic r,
                        input logic lh, input logic rh, input logic cl,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    rs1 = a; rs2 = b;
    uop_div = d; uop_mul = m; uop_rem = r;
    mod_lh_sign = lh; mod_rh_sign = rh; mod_carryless = cl;
    valid = 1'b1; flush = 1'b0;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!ready && lat < 100);
    res = result;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    reset = 1'b0;
  endtask

  task automatic test_mul_unsigned;
    logic [63:0] res; int lat;
    run_op(0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    total++; if (res !== 64'hFFFFFFFE00000001) begin bad++; $display("FAIL mulu_res got=%h exp=fffffffe00000001", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL mulu_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_mul_signed;
    logic [63:0] res; int lat;
    run_op(0, 1, 0, 1, 1, 0, 32'hFFFFFFFD, 32'd7, res, lat);
    total++; if (res !== 64'hFFFFFFFFFFFFFFEB) begin bad++; $display("FAIL mulss_res got=%h exp=ffffffffffffffeb", res); end
    run_op(0, 1, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd2, res, lat);
    total++; if (res !== 64'hFFFFFFFFFFFFFFFE) begin bad++; $display("FAIL mulsu_res got=%h exp=fffffffffffffffe", res); end
    run_op(0, 1, 0, 0, 1, 0, 32'd3, 32'hFFFFFFFF, res, lat);
    total++; if (res !== 64'hFFFFFFFFFFFFFFFD) begin bad++; $display("FAIL mulus_res got=%h exp=fffffffffffffffd", res); end
  endtask

  task automatic test_clmul;
    logic [63:0] res; int lat;
    run_op(0, 1, 0, 0, 0, 1, 32'h3, 32'h3, res, lat);
    total++; if (res !== 64'h5) begin bad++; $display("FAIL clmul_small got=%h exp=5", res); end
    run_op(0, 1, 0, 1, 1, 1, 32'h80000000, 32'h80000000, res, lat);
    total++; if (res !== 64'h4000000000000000) begin bad++; $display("FAIL clmul_top got=%h exp=4000000000000000", res); end
    run_op(0, 1, 0, 0, 0, 1, 32'h7, 32'h7, res, lat);
    total++; if (res !== 64'h15) begin bad++; $display("FAIL clmul_77 got=%h exp=15", res); end
  endtask

  task automatic test_div;
    logic [63:0] res; int lat;
    run_op(1, 0, 0, 1, 0, 0, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total++; if (res !== 64'h0000000080000000) begin bad++; $display("FAIL div_ovf got=%h exp=0000000080000000", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
    run_op(0, 0, 1, 1, 0, 0, 32'h80000000, 32'hFFFFFFFF, res, lat);
    total++; if (res !== 64'h0) begin bad++; $display("FAIL rem_ovf got=%h exp=0", res); end
    run_op(0, 0, 1, 1, 0, 0, 32'hFFFFFFF9, 32'd2, res, lat);
    total++; if (res !== 64'h00000000FFFFFFFF) begin bad++; $display("FAIL rem_neg got=%h exp=00000000ffffffff", res); end
    run_op(1, 0, 0, 1, 0, 0, 32'hFFFFFFF9, 32'd2, res, lat);
    total++; if (res !== 64'h00000000FFFFFFFD) begin bad++; $display("FAIL div_neg got=%h exp=00000000fffffffd", res); end
    run_op(1, 0, 0, 0, 0, 0, 32'hFFFFFFF9, 32'd2, res, lat);
    total++; if (res !== 64'h000000007FFFFFFC) begin bad++; $display("FAIL divu got=%h exp=000000007ffffffc", res); end
  endtask

  task automatic test_div_zero;
    logic [63:0] res; int lat;
    run_op(1, 0, 0, 0, 0, 0, 32'h1234, 32'h0, res, lat);
    total++; if (res !== 64'h00000000FFFFFFFF) begin bad++; $display("FAIL div0_res got=%h exp=00000000ffffffff", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", lat); end
    run_op(0, 0, 1, 0, 0, 0, 32'h1234, 32'h0, res, lat);
    total++; if (res !== 64'h0000000000001234) begin bad++; $display("FAIL rem0_res got=%h exp=1234", res); end
    total++; if (lat !== 1) begin bad++; $display("FAIL rem0_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_abort_flush;
    logic [63:0] res; int lat; int seen;
    seen = 0;
    rs1 = 32'hFFFF; rs2 = 32'hFFFF;
    uop_div = 0; uop_mul = 1; uop_rem = 0;
    mod_lh_sign = 0; mod_rh_sign = 0; mod_carryless = 0;
    valid = 1; flush = 0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock); #1;
      if (ready) seen++;
    end
    flush = 1;
    @(posedge clock); #1;
    flush = 0; valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (ready) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_ready got=%0d exp=0", seen); end
    run_op(0, 1, 0, 0, 0, 0, 32'd5, 32'd6, res, lat);
    total++; if (res !== 64'd30) begin bad++; $display("FAIL abort_next got=%h exp=1e", res); end
  endtask

  task automatic test_reset_mid_div;
    logic [63:0] res; int lat;
    rs1 = 32'd1000; rs2 = 32'd3;
    uop_div = 1; uop_mul = 0; uop_rem = 0;
    mod_lh_sign = 0; mod_rh_sign = 0; mod_carryless = 0;
    valid = 1; flush = 0;
    repeat (5) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", ready); end
    total++; if (result !== 64'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result); end
    reset = 0; valid = 0;
    @(posedge clock); #1;
    run_op(1, 0, 0, 0, 0, 0, 32'd1000, 32'd3, res, lat);
    total++; if (res !== 64'd333) begin bad++; $display("FAIL rstmid_next got=%h exp=14d", res); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] res; int lat;
    run_op(0, 1, 0, 0, 0, 0, 32'd9, 32'd9, res, lat);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL b2b_flush_ready got=%b exp=0", ready); end
    total++; if (res !== 64'd81) begin bad++; $display("FAIL b2b_first got=%h exp=51", res); end
    run_op(0, 0, 1, 0, 0, 0, 32'd100, 32'd7, res, lat);
    total++; if (res !== 64'd2) begin bad++; $display("FAIL b2b_second got=%h exp=2", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_illegal;
    int seen;
    seen = 0;
    rs1 = 32'd5; rs2 = 32'd6;
    mod_lh_sign = 0; mod_rh_sign = 0; mod_carryless = 0;
    uop_div = 1; uop_mul = 1; uop_rem = 0; valid = 1; flush = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (ready) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL illegal_multi got=%0d exp=0", seen); end
    seen = 0;
    uop_div = 0; uop_mul = 0; uop_rem = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (ready) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL illegal_none got=%0d exp=0", seen); end
    valid = 0;
  endtask

  task automatic test_ignore_changes;
    int lat;
    rs1 = 32'd5; rs2 = 32'd6;
    uop_div = 0; uop_mul = 1; uop_rem = 0;
    mod_lh_sign = 0; mod_rh_sign = 0; mod_carryless = 0;
    valid = 1; flush = 0;
    lat = 0;
    repeat (3) begin @(posedge clock); lat++; end
    #1;
    rs1 = 32'd7; rs2 = 32'd9; uop_mul = 0; uop_div = 1; mod_lh_sign = 1; valid = 0;
    while (!ready && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    total++; if (result !== 64'd30 || ready !== 1'b1) begin bad++; $display("FAIL ignore_changes got=%h/%b exp=1e/1", result, ready); end
    flush = 1;
    @(posedge clock); #1;
    flush = 0; uop_div = 0; mod_lh_sign = 0;
  endtask

  task automatic test_xlen64;
    int lat;
    rs1_w = 64'h8000000000000000; rs2_w = 64'd2;
    valid_w = 1; flush_w = 0;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!ready_w && lat < 200);
    total++; if (result_w !== 128'h00000000000000010000000000000000) begin bad++; $display("FAIL x64_res got=%h exp=2^64", result_w); end
    total++; if (lat !== 66) begin bad++; $display("FAIL x64_latency got=%0d exp=66", lat); end
    flush_w = 1;
    @(posedge clock); #1;
    flush_w = 0; valid_w = 0;
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0; valid = 0; flush = 0;
    uop_div = 0; uop_mul = 0; uop_rem = 0;
    mod_lh_sign = 0; mod_rh_sign = 0; mod_carryless = 0;
    rs1_w = 0; rs2_w = 0; valid_w = 0; flush_w = 0;
    @(posedge clock); #1;
    test_reset;
    test_mul_unsigned;
    test_mul_signed;
    test_clmul;
    test_div;
    test_div_zero;
    test_abort_flush;
    test_reset_mid_div;
    test_back_to_back;
    test_illegal;
    test_ignore_changes;
    test_xlen64;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xc_malu_iter.md
XC_MALU_ITER -- requirements
Module: xc_malu_iter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: XLEN, default 32, operand width; legal values 32 and 64.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rs1  input  XLEN  left operand (dividend or multiplicand).
REQ-006 rs2  input  XLEN  right operand (divisor or multiplier).
REQ-007 valid  input  1  request present; held high with stable inputs until flush.
REQ-008 flush  input  1  abort or retire the current operation; the system drives it as valid && ready.
REQ-009 uop_div, uop_mul, uop_rem  input  1 each  one-hot operation select.
REQ-010 mod_lh_sign, mod_rh_sign  input  1 each  rs1 / rs2 are two's-complement signed.
REQ-011 mod_carryless  input  1  carryless (GF(2)) multiply; valid only with uop_mul.
REQ-012 result  output  2*XLEN  operation result.
REQ-013 ready  output  1  result valid.

Function
REQ-014 The module SHALL implement states IDLE, MUL, DIV, FIX and DONE, plus a counter of width clog2(XLEN)+1.
REQ-015 From IDLE with valid=1 and flush=0, the module SHALL capture the operands and op bits.
- The captured values include operand magnitudes when the sign mods are set.
- The next state is MUL (uop_mul), or DIV (uop_div/uop_rem with rs2!=0), or DONE (uop_div/uop_rem with rs2==0).
- The counter is cleared.
REQ-016 MUL SHALL process one multiplier bit per cycle (shift-add, or shift-XOR when carryless) for exactly XLEN cycles, then go to FIX.
REQ-017 DIV SHALL perform one restoring-division step per cycle for exactly XLEN cycles, then go to FIX.
REQ-018 FIX SHALL last one cycle, apply the sign correction, load result and go to DONE.
- Sign correction: negate the product if the operand signs differ; negate the quotient if the signs differ; give the remainder the sign of the dividend.
REQ-019 Latency SHALL be XLEN+2 cycles from the start edge to the first ready=1 edge; the divide-by-zero path SHALL take exactly 1 cycle.
REQ-020 In DONE, ready SHALL be 1 and result SHALL be held stable until flush=1, which SHALL return the state to IDLE with ready=0 on the next edge.
REQ-021 flush=1 in MUL, DIV or FIX SHALL abort the operation: next state IDLE, ready stays 0, result unchanged.
- flush=1 in IDLE SHALL block a start in that cycle.
REQ-022 After flush the module SHALL accept a new valid on the very next cycle (back-to-back operation).
REQ-023 Operand or op changes after capture SHALL be ignored; valid falling while busy SHALL NOT abort.
REQ-024 Mul signedness SHALL honour all four lh/rh sign combinations and produce the full 2*XLEN product.
REQ-025 Carryless mode SHALL ignore the sign mods and SHALL return the XOR of (rs1<<i) for every set bit i of rs2, over 2*XLEN bits.
REQ-026 div/rem SHALL use mod_lh_sign for both operands; result[2*XLEN-1:XLEN] SHALL be zero for div/rem.
REQ-027 Divide by zero SHALL return quotient all-ones (XLEN bits) and remainder rs1.
REQ-028 Signed overflow (most-negative / -1) SHALL return quotient = most-negative and remainder = 0.
REQ-029 Illegal op encodings (zero or multiple op bits set) at start SHALL be treated as no request; the state stays IDLE.

Reset
REQ-030 reset=1 SHALL force, at the next edge: state IDLE, counter 0, ready 0, result 0, and all internal accumulators 0.
REQ-031 Reset SHALL take priority over valid and flush, and SHALL abort any operation in progress with no residual effect on the next request.

Verification (XLEN=32 unless stated)
REQ-032 Unsigned mul: 0xFFFFFFFF * 0xFFFFFFFF -> result 0xFFFFFFFE00000001, with ready first high 34 cycles after the start edge.
REQ-033 Signed-signed mul: -3 * 7 -> result 0xFFFFFFFFFFFFFFEB; signed-unsigned mul: 0xFFFFFFFF * 2 -> result 0xFFFFFFFFFFFFFFFE.
REQ-034 Carryless mul: 0x3 * 0x3 -> result 0x5; 0x80000000 * 0x80000000 -> result 0x4000000000000000.
REQ-035 Signed div of 0x80000000 / 0xFFFFFFFF -> result 0x0000000080000000; rem of the same operands -> result 0; signed rem of -7 % 2 -> result 0x00000000FFFFFFFF.
REQ-036 Div of 0x1234 / 0 -> result 0x00000000FFFFFFFF with ready after 1 cycle; rem of 0x1234 % 0 -> result 0x0000000000001234.
REQ-037 Aborts:
- flush on cycle 10 of a mul -> ready never rises, and a following mul 5 * 6 -> result 30.
- reset mid-div -> all outputs 0 at the next edge.
- With XLEN=64, unsigned mul 2^63 * 2 -> result 2^64, with latency 66.
